// File: rtl/spu32_bus_sram8_pkg.sv
// -----------------------------------------------------------------------------
// spu32_bus_sram8_pkg
//
// Shared definitions for the CPU-bus to 8-bit asynchronous SRAM responder:
//   - sram8_state_t : responder FSM state encoding
//   - SRAM8_BYTES_* : number of SRAM byte accesses per bus access width
//   - SRAM8_WAIT_CNT_W : width of the per-byte access-time down-counter,
//                        sized for WAIT_CYCLES up to 15
//   - sram8_req_bytes() : decodes the bus width flags into a byte count
// -----------------------------------------------------------------------------
package spu32_bus_sram8_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_RECOVER = 3'd3,
    ST_DONE    = 3'd4
  } sram8_state_t;

  localparam logic [2:0] SRAM8_BYTES_BYTE = 3'd1;
  localparam logic [2:0] SRAM8_BYTES_HALF = 3'd2;
  localparam logic [2:0] SRAM8_BYTES_WORD = 3'd4;

  localparam int SRAM8_WAIT_CNT_W = 4;

  // Fullword wins when both width flags are set.
  function automatic logic [2:0] sram8_req_bytes(input logic halfword,
                                                 input logic fullword);
    if (fullword)      return SRAM8_BYTES_WORD;
    else if (halfword) return SRAM8_BYTES_HALF;
    else               return SRAM8_BYTES_BYTE;
  endfunction

endpackage

// File: rtl/spu32_bus_sram8.sv
// -----------------------------------------------------------------------------
// spu32_bus_sram8
//
// CPU bus responder for an asynchronous 8-bit external SRAM. Each byte,
// halfword or fullword request is serialised into 1, 2 or 4 little-endian
// byte accesses at consecutive (wrapping) SRAM addresses. The CPU is held off
// with O_bus_wait until the sequence completes; O_bus_wait drops for exactly
// one cycle (DONE) in which read data on O_bus_data is valid.
//
// Per byte: one SETUP cycle (address/data/CE set up, WE high) followed by
// WAIT_CYCLES ACCESS cycles (WE or OE low). Read bytes are sampled on the
// final ACCESS cycle.
//
// Optional feature (compile-time macro SPU32_SRAM8_WRITE_RECOVERY_EN):
//   when defined, a RECOVER cycle follows the last write byte, with CE
//   released but the data pads still driven, before DONE.
//
// Parameters:
//   ADDR_WIDTH  - SRAM byte address width (bus address bits above are ignored)
//   WAIT_CYCLES - WE/OE low time per byte in clocks, 1..15
//
// Ports:
//   I_clk, I_reset_n                      clock, synchronous active-low reset
//   I_bus_strobe/write/halfword/fullword  request and its attributes
//   I_bus_addr, I_bus_data                byte address, write data
//   O_bus_data, O_bus_wait                read data, busy
//   O_sram_addr, O_sram_data              SRAM address and write data
//   O_sram_data_oe                        data pad output enable
//   I_sram_data                           SRAM read data
//   O_sram_ce_n/oe_n/we_n                 SRAM strobes, active low
// -----------------------------------------------------------------------------
module spu32_bus_sram8
  import spu32_bus_sram8_pkg::*;
#(
  parameter int ADDR_WIDTH  = 19,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  I_clk,
  input  logic                  I_reset_n,
  input  logic                  I_bus_strobe,
  input  logic                  I_bus_write,
  input  logic                  I_bus_halfword,
  input  logic                  I_bus_fullword,
  input  logic [31:0]           I_bus_addr,
  input  logic [31:0]           I_bus_data,
  output logic [31:0]           O_bus_data,
  output logic                  O_bus_wait,
  output logic [ADDR_WIDTH-1:0] O_sram_addr,
  output logic [7:0]            O_sram_data,
  output logic                  O_sram_data_oe,
  input  logic [7:0]            I_sram_data,
  output logic                  O_sram_ce_n,
  output logic                  O_sram_oe_n,
  output logic                  O_sram_we_n
);

  localparam logic [SRAM8_WAIT_CNT_W-1:0] WAIT_RELOAD =
    SRAM8_WAIT_CNT_W'(WAIT_CYCLES - 1);

  sram8_state_t                state;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [31:0]                 wdata_q;
  logic                        write_q;
  logic [1:0]                  last_idx;
  logic [1:0]                  byte_idx;
  logic [SRAM8_WAIT_CNT_W-1:0] wait_cnt;
  logic [31:0]                 rdata_acc;

  logic [1:0]  next_idx;
  logic [31:0] rdata_merged;
  logic [2:0]  req_bytes;
  logic        unused_addr_bits;

  // Extract byte idx of a little-endian word.
  function automatic logic [7:0] byte_sel(input logic [31:0] word,
                                          input logic [1:0]  idx);
    logic [31:0] shifted;
    shifted = word >> {idx, 3'b000};
    return shifted[7:0];
  endfunction

  // OR a byte into its lane; the accumulator starts zeroed, so unused
  // upper lanes stay zero-filled.
  function automatic logic [31:0] byte_merge(input logic [31:0] word,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
    return word | ({24'd0, b} << {idx, 3'b000});
  endfunction

  assign O_bus_wait       = I_bus_strobe & (state != ST_DONE);
  assign next_idx         = byte_idx + 2'd1;
  assign rdata_merged     = byte_merge(rdata_acc, byte_idx, I_sram_data);
  assign req_bytes        = sram8_req_bytes(I_bus_halfword, I_bus_fullword);
  assign unused_addr_bits = ^I_bus_addr[31:ADDR_WIDTH];

  // All SRAM pins are registered and loaded on the transition into the state
  // whose pin values they represent, so they are glitch-free at the pads.
  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      state          <= ST_IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      write_q        <= 1'b0;
      last_idx       <= '0;
      byte_idx       <= '0;
      wait_cnt       <= '0;
      rdata_acc      <= '0;
      O_bus_data     <= '0;
      O_sram_addr    <= '0;
      O_sram_data    <= '0;
      O_sram_data_oe <= 1'b0;
      O_sram_ce_n    <= 1'b1;
      O_sram_oe_n    <= 1'b1;
      O_sram_we_n    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (I_bus_strobe) begin
            addr_q      <= I_bus_addr[ADDR_WIDTH-1:0];
            wdata_q     <= I_bus_data;
            write_q     <= I_bus_write;
            last_idx    <= 2'(req_bytes - 3'd1);
            byte_idx    <= 2'd0;
            rdata_acc   <= '0;
            O_sram_addr <= I_bus_addr[ADDR_WIDTH-1:0];
            O_sram_ce_n <= 1'b0;
            O_sram_we_n <= 1'b1;
            if (I_bus_write) begin
              O_sram_data    <= I_bus_data[7:0];
              O_sram_data_oe <= 1'b1;
              O_sram_oe_n    <= 1'b1;
            end else begin
              O_sram_data_oe <= 1'b0;
              O_sram_oe_n    <= 1'b0;
            end
            state <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (write_q) begin
            O_sram_we_n <= 1'b0;
          end
          wait_cnt <= WAIT_RELOAD;
          state    <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else begin
            if (!write_q) begin
              rdata_acc <= rdata_merged;
            end
            if (byte_idx == last_idx) begin
              // Last byte: release the SRAM; reads publish their result.
              if (!write_q) begin
                O_bus_data <= rdata_merged;
              end
              O_sram_ce_n <= 1'b1;
              O_sram_oe_n <= 1'b1;
              O_sram_we_n <= 1'b1;
`ifdef SPU32_SRAM8_WRITE_RECOVERY_EN
              // Keep driving write data one extra cycle past CE release.
              if (write_q) begin
                state <= ST_RECOVER;
              end else begin
                O_sram_data_oe <= 1'b0;
                state          <= ST_DONE;
              end
`else
              O_sram_data_oe <= 1'b0;
              state          <= ST_DONE;
`endif
            end else begin
              // Next byte: WE rises here, terminating the current write.
              byte_idx    <= next_idx;
              O_sram_addr <= addr_q + ADDR_WIDTH'(next_idx);
              O_sram_we_n <= 1'b1;
              if (write_q) begin
                O_sram_data <= byte_sel(wdata_q, next_idx);
              end
              state <= ST_SETUP;
            end
          end
        end

`ifdef SPU32_SRAM8_WRITE_RECOVERY_EN
        ST_RECOVER: begin
          O_sram_data_oe <= 1'b0;
          state          <= ST_DONE;
        end
`endif

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spu32_bus_sram8.sv
// -----------------------------------------------------------------------------
// tb_spu32_bus_sram8
//
// Bench for spu32_bus_sram8 with a behavioural asynchronous 8-bit SRAM
// (written while CE and WE are low, read combinationally while CE and OE are
// low). Bus requests push their expected latency and read data into a
// scoreboard; a monitor pops and compares whenever the responder drops wait.
// -----------------------------------------------------------------------------
module tb_spu32_bus_sram8;

  localparam int AW = 19;

`ifdef SPU32_SRAM8_WRITE_RECOVERY_EN
  localparam int WR_EXTRA = 1;
`else
  localparam int WR_EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          bus_strobe = 1'b0;
  logic          bus_write = 1'b0;
  logic          bus_halfword = 1'b0;
  logic          bus_fullword = 1'b0;
  logic [31:0]   bus_addr = '0;
  logic [31:0]   bus_wdata = '0;
  logic [31:0]   bus_rdata;
  logic          bus_wait;
  logic [AW-1:0] sram_addr;
  logic [7:0]    sram_wdata;
  logic          sram_data_oe;
  logic [7:0]    sram_rdata;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;

  spu32_bus_sram8 #(
    .ADDR_WIDTH (AW),
    .WAIT_CYCLES(1)
  ) dut (
    .I_clk          (clk),
    .I_reset_n      (reset_n),
    .I_bus_strobe   (bus_strobe),
    .I_bus_write    (bus_write),
    .I_bus_halfword (bus_halfword),
    .I_bus_fullword (bus_fullword),
    .I_bus_addr     (bus_addr),
    .I_bus_data     (bus_wdata),
    .O_bus_data     (bus_rdata),
    .O_bus_wait     (bus_wait),
    .O_sram_addr    (sram_addr),
    .O_sram_data    (sram_wdata),
    .O_sram_data_oe (sram_data_oe),
    .I_sram_data    (sram_rdata),
    .O_sram_ce_n    (sram_ce_n),
    .O_sram_oe_n    (sram_oe_n),
    .O_sram_we_n    (sram_we_n)
  );

  always #5 clk = ~clk;

  // SRAM model
  logic [7:0] mem [0:(1<<AW)-1];

  assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 8'h00;

  always @(negedge clk) begin
    if (!sram_ce_n && !sram_we_n) mem[sram_addr] = sram_wdata;
  end

  // Bookkeeping
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!sram_we_n && !sram_oe_n) viol = viol + 1;
    if (!sram_oe_n && sram_data_oe) viol = viol + 1;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    string       name;
    int          start;
    int          lat;
    bit          rd;
    logic [31:0] data;
  } sb_t;

  sb_t sb[$];

  // Monitor: one scoreboard entry per completed request
  always @(negedge clk) begin
    if (bus_strobe && !bus_wait) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got completion at cycle %0d expected none", cyc);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk({e.name, "_latency"}, 32'(cyc - e.start), 32'(e.lat));
        if (e.rd) chk({e.name, "_rdata"}, bus_rdata, e.data);
      end
    end
  end

  task automatic bus_req(input string name, input bit wr, input bit half,
                         input bit full, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat,
                         input logic [31:0] exp);
    int  n;
    bit  done;
    sb_t e;
    @(posedge clk); #1;
    bus_strobe   = 1'b1;
    bus_write    = wr;
    bus_halfword = half;
    bus_fullword = full;
    bus_addr     = addr;
    bus_wdata    = wdata;
    e.name = name; e.start = cyc; e.lat = lat; e.rd = !wr; e.data = exp;
    sb.push_back(e);
    n = 0;
    done = 1'b0;
    while (!done && n < 100) begin
      @(negedge clk);
      if (!bus_wait) done = 1'b1;
      n++;
    end
    if (!done) begin
      checks++;
      $display("FAIL %s_timeout: got wait high for %0d cycles expected completion", name, n);
      if (sb.size() > 0) void'(sb.pop_back());
    end
    @(posedge clk); #1;
    bus_strobe = 1'b0;
  endtask

  // Request whose strobe is withdrawn two cycles in.
  task automatic bus_req_drop(input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata);
    @(posedge clk); #1;
    bus_strobe   = 1'b1;
    bus_write    = wr;
    bus_halfword = 1'b0;
    bus_fullword = 1'b1;
    bus_addr     = addr;
    bus_wdata    = wdata;
    repeat (2) @(posedge clk);
    #1;
    bus_strobe = 1'b0;
    repeat (14) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    mem[32'h104] = 8'h77;
    mem[32'h200] = 8'h11;
    mem[32'h201] = 8'h22;
    mem[32'h202] = 8'h33;
    mem[32'h203] = 8'h44;
    mem[32'h301] = 8'h99;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_data_oe", 32'(sram_data_oe), 32'd0);
    chk("rst_bus_data", bus_rdata, 32'h0);
    chk("rst_sram_addr", 32'(sram_addr), 32'h0);
    chk("rst_wait", 32'(bus_wait), 32'd0);
    reset_n = 1'b1;

    // Fullword write / read and sub-word reads, misaligned included
    bus_req("wr_word", 1, 0, 1, 32'h100, 32'hDEADBEEF, 9 + 4*WR_EXTRA/4 + (WR_EXTRA - WR_EXTRA), 32'h0);
    chk("mem_100", 32'(mem[32'h100]), 32'hEF);
    chk("mem_101", 32'(mem[32'h101]), 32'hBE);
    chk("mem_102", 32'(mem[32'h102]), 32'hAD);
    chk("mem_103", 32'(mem[32'h103]), 32'hDE);
    bus_req("rd_word", 0, 0, 1, 32'h100, 32'h0, 9, 32'hDEADBEEF);
    bus_req("rd_byte", 0, 0, 0, 32'h102, 32'h0, 3, 32'h000000AD);
    bus_req("rd_half_mis", 0, 1, 0, 32'h101, 32'h0, 5, 32'h0000ADBE);

    // Halfword write across the top of the address space
    bus_req("wr_half_wrap", 1, 1, 0, 32'h0007FFFF, 32'h00001234, 5 + WR_EXTRA, 32'h0);
    chk("mem_7ffff", 32'(mem[32'h7FFFF]), 32'h34);
    chk("mem_00000", 32'(mem[32'h0]), 32'h12);
    bus_req("rd_half_wrap", 0, 1, 0, 32'hFFF7FFFF, 32'h0, 5, 32'h00001234);

    // Byte write touches one byte only
    bus_req("wr_byte", 1, 0, 0, 32'h300, 32'hFFFFFF5A, 3 + WR_EXTRA, 32'h0);
    chk("mem_300", 32'(mem[32'h300]), 32'h5A);
    chk("mem_301", 32'(mem[32'h301]), 32'h99);
    bus_req("rd_byte_300", 0, 0, 0, 32'h300, 32'h0, 3, 32'h0000005A);

    // Both width flags set behaves as fullword
    bus_req("rd_both", 0, 1, 1, 32'h100, 32'h0, 9, 32'hDEADBEEF);

    // Strobe withdrawn mid-access: sequence still completes
    bus_req_drop(0, 32'h101, 32'h0);
    chk("drop_rd_data", bus_rdata, 32'h77DEADBE);
    chk("drop_rd_idle_ce", 32'(sram_ce_n), 32'd1);
    bus_req_drop(1, 32'h400, 32'hA5A55A5A);
    chk("drop_wr_400", 32'(mem[32'h400]), 32'h5A);
    chk("drop_wr_401", 32'(mem[32'h401]), 32'h5A);
    chk("drop_wr_402", 32'(mem[32'h402]), 32'hA5);
    chk("drop_wr_403", 32'(mem[32'h403]), 32'hA5);

    // Reset during fullword write, in SETUP of byte 1
    @(posedge clk); #1;
    bus_strobe   = 1'b1;
    bus_write    = 1'b1;
    bus_halfword = 1'b0;
    bus_fullword = 1'b1;
    bus_addr     = 32'h200;
    bus_wdata    = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_pre_addr", 32'(sram_addr), 32'h201);
    chk("midrst_pre_data", 32'(sram_wdata), 32'hF0);
    chk("midrst_pre_ce", 32'(sram_ce_n), 32'd0);
    reset_n    = 1'b0;
    bus_strobe = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("midrst_we_n", 32'(sram_we_n), 32'd1);
    chk("midrst_data_oe", 32'(sram_data_oe), 32'd0);
    chk("midrst_bus_data", bus_rdata, 32'h0);
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_mem_200", 32'(mem[32'h200]), 32'h0D);
    chk("midrst_mem_201", 32'(mem[32'h201]), 32'h22);
    chk("midrst_mem_202", 32'(mem[32'h202]), 32'h33);
    chk("midrst_mem_203", 32'(mem[32'h203]), 32'h44);

    // Responder usable again after reset
    bus_req("post_rst_rd", 0, 0, 1, 32'h100, 32'h0, 9, 32'hDEADBEEF);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("strobe_invariants", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
